// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
// Holds the FSM encoding, the bus word type and the default I/O location.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } mem_state_t;

  typedef logic [15:0] word_t;

  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

  // Counter preload for a given wait-state count; zero wait states never enters WAIT.
  function automatic logic [3:0] wait_load(input int unsigned ws);
    return (ws == 0) ? 4'd0 : 4'(ws - 1);
  endfunction

endpackage

// File: rtl/slc3_sync_ram.sv
// Single-port word RAM, synchronous write and registered read (one-cycle latency).
// Contents have no reset so a bus reset leaves memory intact.
module slc3_sync_ram
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem_q [DEPTH];
  word_t rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR bus: wait-stated RAM accesses,
// switch/hex memory-mapped I/O at IO_ADDR, and a sticky out-of-range flag.
//
// state | meaning
// IDLE  | waiting for MEM_EN; captures MAR/MEM_WE/MDR_out on request
// WAIT  | counting down wait states on the captured request
// RESP  | one cycle; read data / write commit / R happen on its closing edge
// HOLD  | waiting for MEM_EN to drop so one request yields one access
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEF)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              MEM_EN,
  input  logic              MEM_WE,
  input  logic [ADDR_W-1:0] MAR,
  input  word_t             MDR_out,
  input  word_t             SW,
  output word_t             MDR_in,
  output logic              R,
  output word_t             hex_out,
  output logic              oob_err
);

  localparam int                AW        = $clog2(DEPTH);
  localparam logic [3:0]        WAIT_LOAD = wait_load(WAIT_STATES);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  word_t             wdata_q, wdata_d;
  word_t             mdr_q, mdr_d;
  logic              r_q, r_d;
  word_t             hex_q, hex_d;
  logic              oob_q, oob_d;

  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  word_t             ram_rdata;
  logic              is_io;
  logic              in_ram;

  assign is_io  = (addr_q == IO_ADDR);
  assign in_ram = !is_io && ({1'b0, addr_q} < DEPTH_LIM);

  slc3_sync_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (Clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    mdr_d    = mdr_q;
    r_d      = 1'b0;
    hex_d    = hex_q;
    oob_d    = oob_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q[AW-1:0];

    case (state_q)
      IDLE: begin
        if (MEM_EN) begin
          addr_d  = MAR;
          we_d    = MEM_WE;
          wdata_d = MDR_out;
          cnt_d   = WAIT_LOAD;
          if (WAIT_STATES == 0) begin
            // No wait states: the RAM read must launch straight from the bus address.
            state_d  = RESP;
            ram_en   = !MEM_WE;
            ram_addr = MAR[AW-1:0];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          ram_en  = !we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        r_d     = 1'b1;
        state_d = HOLD;
        if (is_io) begin
          if (we_q) hex_d = wdata_q;
          else      mdr_d = SW;
        end else if (in_ram) begin
          if (we_q) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end else begin
            mdr_d = ram_rdata;
          end
        end else begin
          if (!we_q) mdr_d = '0;
          oob_d = 1'b1;
        end
      end
      HOLD: begin
        if (!MEM_EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      mdr_q   <= '0;
      r_q     <= 1'b0;
      hex_q   <= '0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      mdr_q   <= mdr_d;
      r_q     <= r_d;
      hex_q   <= hex_d;
      oob_q   <= oob_d;
    end
  end

  assign MDR_in  = mdr_q;
  assign R       = r_q;
  assign hex_out = hex_q;
  assign oob_err = oob_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: transaction-level reference model checked every cycle,
// directed scenarios pinned with literal values, randomized accesses, and a zero-wait instance.
module tb_slc3_mem_responder;
  import slc3_mem_pkg::*;

  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        MEM_EN = 1'b0, MEM_WE = 1'b0;
  logic [15:0] MAR = '0;
  word_t       MDR_out = '0, SW = '0;
  word_t       MDR_in, hex_out;
  logic        R, oob_err;

  logic        en0 = 1'b0, we0 = 1'b0;
  logic [15:0] mar0 = '0;
  word_t       mdo0 = '0;
  word_t       mdr0, hex0;
  logic        r0, oob0;

  slc3_mem_responder #(.ADDR_W(16), .DEPTH(1024), .WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MAR(MAR),
    .MDR_out(MDR_out), .SW(SW), .MDR_in(MDR_in), .R(R), .hex_out(hex_out), .oob_err(oob_err)
  );

  slc3_mem_responder #(.ADDR_W(16), .DEPTH(1024), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .MEM_EN(en0), .MEM_WE(we0), .MAR(mar0),
    .MDR_out(mdo0), .SW(SW), .MDR_in(mdr0), .R(r0), .hex_out(hex0), .oob_err(oob0)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model: memory image, output values, one pending request with its due cycle.
  word_t       mem_m [1024];
  bit          mem_v [1024];
  word_t       mdr_m = '0, hex_m = '0;
  bit          oob_m = 1'b0;
  bit          exp_r = 1'b0;
  bit          pend = 1'b0;
  bit          p_we = 1'b0;
  logic [15:0] p_addr = '0;
  word_t       p_data = '0;
  int          p_cyc = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge Clk);
    exp_r = 1'b0;
    if (!Reset_n) begin
      pend  = 1'b0;
      mdr_m = '0;
      hex_m = '0;
      oob_m = 1'b0;
    end else if (pend && cyc == p_cyc) begin
      exp_r = 1'b1;
      pend  = 1'b0;
      if (p_addr == 16'hFFFF) begin
        if (p_we) hex_m = p_data;
        else      mdr_m = SW;
      end else if (p_addr < 16'd1024) begin
        if (p_we) begin
          mem_m[p_addr[9:0]] = p_data;
          mem_v[p_addr[9:0]] = 1'b1;
        end else begin
          mdr_m = mem_m[p_addr[9:0]];
        end
      end else begin
        if (!p_we) mdr_m = '0;
        oob_m = 1'b1;
      end
    end
    chk("r", R, exp_r);
    chk("mdr_in", MDR_in, mdr_m);
    chk("hex_out", hex_out, hex_m);
    chk("oob_err", oob_err, oob_m);
  end

  // One core request on the WS-wait instance; bus inputs are scrambled while it is in flight.
  task automatic acc(input bit we, input logic [15:0] addr, input word_t data,
                     input int hold, input bit early, output word_t rd, output int lat);
    @(posedge Clk); #1;
    MEM_EN = 1'b1; MEM_WE = we; MAR = addr; MDR_out = data;
    p_we = we; p_addr = addr; p_data = data; p_cyc = cyc + WS + 2; pend = 1'b1;
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (R) begin
        lat = n;
        rd  = MDR_in;
        break;
      end
      @(posedge Clk); #1;
      MAR     = 16'($urandom);
      MDR_out = 16'($urandom);
      MEM_WE  = 1'($urandom);
      if (early && cyc == p_cyc - 1) MEM_EN = 1'b0;
    end
    chk("r_seen", 16'(lat != 0), 16'd1);
    repeat (hold) @(posedge Clk);
    if (MEM_EN) begin
      @(posedge Clk); #1;
      MEM_EN = 1'b0;
    end
    MEM_WE = 1'b0;
  endtask

  task automatic acc0(input bit we, input logic [15:0] addr, input word_t data,
                      output word_t rd, output int lat);
    @(posedge Clk); #1;
    en0 = 1'b1; we0 = we; mar0 = addr; mdo0 = data;
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (r0) begin
        lat = n;
        rd  = mdr0;
        break;
      end
    end
    @(posedge Clk); #1;
    en0 = 1'b0;
    @(negedge Clk);
    chk("r0_single", r0, 1'b0);
  endtask

  initial begin
    word_t       rd;
    int          lat;
    bit          we;
    logic [15:0] addr;
    int          kind, idx;

    #2 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_r", R, 1'b0);
    chk("rst_mdr", MDR_in, 16'h0000);
    chk("rst_hex", hex_out, 16'h0000);
    chk("rst_oob", oob_err, 1'b0);
    Reset_n = 1'b1;

    acc(1'b1, 16'h0003, 16'h1234, 0, 1'b0, rd, lat);
    acc(1'b0, 16'h0003, 16'h0000, 0, 1'b0, rd, lat);
    chk("t1_rd", rd, 16'h1234);
    chk("t1_lat", 16'(lat), 16'd5);

    acc(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, rd, lat);
    chk("t2_wr_keeps_mdr", MDR_in, 16'h1234);
    acc(1'b0, 16'h0010, 16'h0000, 0, 1'b0, rd, lat);
    chk("t2_rd", rd, 16'hBEEF);

    acc(1'b1, 16'h03FF, 16'h0777, 0, 1'b0, rd, lat);
    SW = 16'h00A5;
    acc(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0, rd, lat);
    chk("t3_sw_rd", rd, 16'h00A5);
    acc(1'b1, 16'hFFFF, 16'h1F2E, 0, 1'b0, rd, lat);
    chk("t3_hex", hex_out, 16'h1F2E);
    acc(1'b0, 16'h03FF, 16'h0000, 0, 1'b0, rd, lat);
    chk("t3_ram_kept", rd, 16'h0777);

    acc(1'b0, 16'h8000, 16'h0000, 0, 1'b0, rd, lat);
    chk("t4_oob_rd", rd, 16'h0000);
    chk("t4_oob_set", oob_err, 1'b1);
    acc(1'b0, 16'h0003, 16'h0000, 0, 1'b0, rd, lat);
    chk("t4_valid_rd", rd, 16'h1234);
    chk("t4_oob_sticky", oob_err, 1'b1);

    acc(1'b0, 16'h0010, 16'h0000, 10, 1'b0, rd, lat);
    chk("t5_hold_rd", rd, 16'hBEEF);
    acc(1'b0, 16'h0003, 16'h0000, 0, 1'b1, rd, lat);
    chk("t5_early_rd", rd, 16'h1234);
    acc(1'b0, 16'h0010, 16'h0000, 0, 1'b0, rd, lat);
    chk("t5_b2b_rd", rd, 16'hBEEF);
    chk("t5_b2b_lat", 16'(lat), 16'd5);

    acc0(1'b1, 16'h0040, 16'h0C0F, rd, lat);
    chk("ws0_wr_lat", 16'(lat), 16'd3);
    acc0(1'b0, 16'h0040, 16'h0000, rd, lat);
    chk("ws0_rd", rd, 16'h0C0F);
    chk("ws0_rd_lat", 16'(lat), 16'd3);
    acc0(1'b0, 16'h9000, 16'h0000, rd, lat);
    chk("ws0_oob_rd", rd, 16'h0000);
    chk("ws0_oob", oob0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      SW   = 16'($urandom);
      we   = 1'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        addr = 16'hFFFF;
      end else if (kind == 1) begin
        addr = 16'(16'h0400 + $urandom_range(0, 16'hFBFE));
      end else begin
        idx  = $urandom_range(0, 15);
        addr = (idx == 15) ? 16'd1023 : 16'(idx * 61);
        if (!mem_v[addr[9:0]]) we = 1'b1;
      end
      acc(we, addr, 16'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0), rd, lat);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end

    acc(1'b1, 16'h0020, 16'h5555, 0, 1'b0, rd, lat);
    @(posedge Clk); #1;
    MEM_EN = 1'b1; MEM_WE = 1'b1; MAR = 16'h0020; MDR_out = 16'hAAAA;
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    MEM_EN  = 1'b0;
    MEM_WE  = 1'b0;
    #1;
    chk("t6_rst_r", R, 1'b0);
    chk("t6_rst_mdr", MDR_in, 16'h0000);
    chk("t6_rst_hex", hex_out, 16'h0000);
    chk("t6_rst_oob", oob_err, 1'b0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    acc(1'b0, 16'h0020, 16'h0000, 0, 1'b0, rd, lat);
    chk("t6_ram_kept", rd, 16'h5555);
    chk("t6_idle_lat", 16'(lat), 16'd5);

    repeat (2) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
